// File: rtl/traffic_mon_pkg.sv
// traffic_mon_pkg
// Shared types and helpers for the traffic-light bus monitor.
//   colour_t   : decoded lamp state of one direction
//   state_t    : monitor FSM state
//   FC_*       : fault cause codes reported on fault_code
//   next_colour: the only legal successor of a lamp colour
//   is_legal   : true for GREEN/YELLOW/RED
package traffic_mon_pkg;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    RED     = 3'd3,
    ILLEGAL = 3'd4
  } colour_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_ENC = 3'd1;
  localparam logic [2:0] FC_CONFLICT    = 3'd2;
  localparam logic [2:0] FC_BAD_ORDER   = 3'd3;
  localparam logic [2:0] FC_SHORT       = 3'd4;
  localparam logic [2:0] FC_LONG        = 3'd5;

  function automatic colour_t next_colour(input colour_t c);
    case (c)
      GREEN:   next_colour = YELLOW;
      YELLOW:  next_colour = RED;
      RED:     next_colour = GREEN;
      default: next_colour = ILLEGAL;
    endcase
  endfunction

  function automatic logic is_legal(input colour_t c);
    is_legal = (c == GREEN) || (c == YELLOW) || (c == RED);
  endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// traffic_light_decode
// Combinational decode of one direction's three lamps into a colour.
// Exactly one lamp lit gives that colour; anything else is ILLEGAL.
// Ports:
//   green, yellow, red : lamp inputs
//   colour             : decoded colour
module traffic_light_decode
  import traffic_mon_pkg::*;
(
  input  logic    green,
  input  logic    yellow,
  input  logic    red,
  output colour_t colour
);

  always_comb begin
    colour = ILLEGAL;
    case ({green, yellow, red})
      3'b100:  colour = GREEN;
      3'b010:  colour = YELLOW;
      3'b001:  colour = RED;
      default: colour = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor
// Passive checker for a two-direction traffic-light bus. Checks lamp
// encoding, conflicts, colour order and phase durations (in one_sec
// ticks) and latches the first violation as a sticky fault.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   one_sec          : one-clk tick pulse per second
//   xanh/vang/do_1,2 : green/yellow/red lamps of direction 1 and 2
//   clr              : single-cycle fault clear
//   fault            : sticky fault flag
//   fault_code       : cause of the latched fault (FC_* codes)
//   fault_dir        : bit0 = dir1 involved, bit1 = dir2 involved
//   cycles           : completed dir1 green-to-green cycles, saturating
//   force_red        : all-red request while faulted
// Build option: define TRAFFIC_MON_FORCE_RED_EN to drive force_red;
// otherwise force_red is tied low.
module traffic_monitor
  import traffic_mon_pkg::*;
#(
  parameter int GREEN_S  = 7,
  parameter int YELLOW_S = 3,
  parameter int RED_S    = 10,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_sec,
  input  logic        xanh_1,
  input  logic        vang_1,
  input  logic        do_1,
  input  logic        xanh_2,
  input  logic        vang_2,
  input  logic        do_2,
  input  logic        clr,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_dir,
  output logic [15:0] cycles,
  output logic        force_red
);

  colour_t          dec_1, dec_2;
  colour_t          cur   [2];
  colour_t          col_q [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_n [2];

  logic [1:0] change, arm_evt;
  logic [1:0] v_illegal, v_order, v_short, v_long;
  logic       v_conflict;
  logic       chk_basic, chk_track;
  logic [2:0] viol_code;
  logic [1:0] viol_dir;

  state_t      state_q, state_n;
  logic        fault_q, fault_n;
  logic [2:0]  code_q, code_n;
  logic [1:0]  dir_q, dir_n;
  logic [1:0]  armed_q, armed_n;
  logic [15:0] cycles_q, cycles_n;

  function automatic logic [CNT_W-1:0] seg_len(input colour_t c);
    case (c)
      GREEN:   seg_len = CNT_W'(GREEN_S);
      YELLOW:  seg_len = CNT_W'(YELLOW_S);
      RED:     seg_len = CNT_W'(RED_S);
      default: seg_len = '1;
    endcase
  endfunction

  traffic_light_decode u_dec_1 (
    .green  (xanh_1),
    .yellow (vang_1),
    .red    (do_1),
    .colour (dec_1)
  );

  traffic_light_decode u_dec_2 (
    .green  (xanh_2),
    .yellow (vang_2),
    .red    (do_2),
    .colour (dec_2)
  );

  // Per-direction change detection, tick counting and raw violation flags.
  // A tick arriving on the change cycle belongs to the new segment, so
  // SHORT compares the finished segment's count (cnt_q) while LONG looks
  // at the count including this cycle's tick (cnt_n).
  always_comb begin
    cur[0] = dec_1;
    cur[1] = dec_2;
    for (int d = 0; d < 2; d++) begin
      change[d] = (cur[d] != col_q[d]);
      if (change[d])
        cnt_n[d] = one_sec ? CNT_W'(1) : '0;
      else if (one_sec && (cnt_q[d] != '1))
        cnt_n[d] = cnt_q[d] + 1'b1;
      else
        cnt_n[d] = cnt_q[d];
      v_illegal[d] = (cur[d] == ILLEGAL);
      v_order[d]   = change[d] && is_legal(col_q[d]) &&
                     (cur[d] != next_colour(col_q[d]));
      v_short[d]   = change[d] && is_legal(col_q[d]) &&
                     (cnt_q[d] < seg_len(col_q[d]));
      v_long[d]    = !change[d] && is_legal(col_q[d]) &&
                     (cnt_n[d] > seg_len(col_q[d]));
      arm_evt[d]   = change[d] && is_legal(col_q[d]) && is_legal(cur[d]);
    end
    v_conflict = (cur[0] != RED) && (cur[1] != RED);
  end

  // Priority selection of the winning fault cause. Encoding and conflict
  // are also evaluated on a clr cycle in FAULT so a violation present
  // during the clear keeps the monitor faulted.
  always_comb begin
    chk_basic = (state_q != FAULT) || clr;
    chk_track = (state_q == TRACK);
    viol_code = FC_NONE;
    viol_dir  = 2'b00;
    if (chk_basic && (|v_illegal)) begin
      viol_code = FC_ILLEGAL_ENC;
      viol_dir  = v_illegal;
    end else if (chk_basic && v_conflict) begin
      viol_code = FC_CONFLICT;
      viol_dir  = 2'b11;
    end else if (chk_track && (|v_order)) begin
      viol_code = FC_BAD_ORDER;
      viol_dir  = v_order;
    end else if (chk_track && (|v_short)) begin
      viol_code = FC_SHORT;
      viol_dir  = v_short;
    end else if (chk_track && (|v_long)) begin
      viol_code = FC_LONG;
      viol_dir  = v_long;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n  = state_q;
    fault_n  = fault_q;
    code_n   = code_q;
    dir_n    = dir_q;
    armed_n  = armed_q;
    cycles_n = cycles_q;
    case (state_q)
      SYNC: begin
        armed_n = armed_q | arm_evt;
        if (viol_code != FC_NONE) begin
          state_n = FAULT;
          fault_n = 1'b1;
          code_n  = viol_code;
          dir_n   = viol_dir;
        end else if (&armed_n) begin
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (change[0] && (cur[0] == GREEN) && (cycles_q != 16'hFFFF))
          cycles_n = cycles_q + 16'd1;
        if (viol_code != FC_NONE) begin
          state_n = FAULT;
          fault_n = 1'b1;
          code_n  = viol_code;
          dir_n   = viol_dir;
        end
      end
      FAULT: begin
        if (clr) begin
          if (viol_code != FC_NONE) begin
            code_n = viol_code;
            dir_n  = viol_dir;
          end else begin
            state_n = SYNC;
            fault_n = 1'b0;
            code_n  = FC_NONE;
            dir_n   = 2'b00;
            armed_n = 2'b00;
          end
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // FSM state and fault outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SYNC;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      dir_q    <= 2'b00;
      armed_q  <= 2'b00;
      cycles_q <= 16'd0;
    end else begin
      state_q  <= state_n;
      fault_q  <= fault_n;
      code_q   <= code_n;
      dir_q    <= dir_n;
      armed_q  <= armed_n;
      cycles_q <= cycles_n;
    end
  end

  // Colour history and tick counters keep following the bus in every
  // state, so after a clear the current segment is simply treated as
  // partial until the next change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        col_q[d] <= NONE;
        cnt_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        col_q[d] <= cur[d];
        cnt_q[d] <= cnt_n[d];
      end
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign cycles     = cycles_q;

`ifdef TRAFFIC_MON_FORCE_RED_EN
  assign force_red = fault_q;
`else
  assign force_red = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor
// Directed self-checking bench for traffic_monitor. Lamps follow a
// 20-second schedule (dir1 G7 Y3 R10, dir2 R10 G7 Y3); lamp changes are
// applied on the same clk as the one_sec tick, with three idle clocks
// between ticks. Outputs are sampled on the falling clock edge.
module tb_traffic_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        one_sec;
  logic        xanh_1, vang_1, do_1;
  logic        xanh_2, vang_2, do_2;
  logic        clr;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  fault_dir;
  logic [15:0] cycles;
  logic        force_red;

  int vectors     = 0;
  int miscompares = 0;

`ifdef TRAFFIC_MON_FORCE_RED_EN
  localparam logic FR_EN = 1'b1;
`else
  localparam logic FR_EN = 1'b0;
`endif

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;

  always #5 clk = ~clk;

  traffic_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .one_sec    (one_sec),
    .xanh_1     (xanh_1),
    .vang_1     (vang_1),
    .do_1       (do_1),
    .xanh_2     (xanh_2),
    .vang_2     (vang_2),
    .do_2       (do_2),
    .clr        (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_dir  (fault_dir),
    .cycles     (cycles),
    .force_red  (force_red)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic f, input logic [2:0] code,
                          input logic [1:0] dir, input logic [15:0] cyc);
    checkOutput({tag, ".fault"},      {15'd0, fault},      {15'd0, f});
    checkOutput({tag, ".fault_code"}, {13'd0, fault_code}, {13'd0, code});
    checkOutput({tag, ".fault_dir"},  {14'd0, fault_dir},  {14'd0, dir});
    checkOutput({tag, ".cycles"},     cycles,              cyc);
    checkOutput({tag, ".force_red"},  {15'd0, force_red},  {15'd0, f & FR_EN});
  endtask

  function automatic logic [5:0] phaseLamps(input int s);
    int p;
    logic [2:0] d1, d2;
    p = s % 20;
    if (p < 7)       d1 = LG;
    else if (p < 10) d1 = LY;
    else             d1 = LR;
    if (p < 10)      d2 = LR;
    else if (p < 17) d2 = LG;
    else             d2 = LY;
    return {d1, d2};
  endfunction

  task automatic setLamps(input logic [5:0] l);
    {xanh_1, vang_1, do_1, xanh_2, vang_2, do_2} = l;
  endtask

  // Drive lamps/tick/clr for exactly one clock, then release the pulses.
  task automatic applyStimulus(input logic [5:0] l, input logic tick, input logic clrIn);
    setLamps(l);
    one_sec = tick;
    clr     = clrIn;
    @(negedge clk);
    one_sec = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic runSeconds(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      applyStimulus(phaseLamps(s), 1'b1, 1'b0);
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    one_sec = 1'b0;
    clr     = 1'b0;
    setLamps(phaseLamps(3));
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset", 1'b0, 3'd0, 2'b00, 16'd0);
    reset = 1'b1;

    // Start mid-green; arming at s=7/s=10, dir1 re-enters green at 20/40/60.
    runSeconds(3, 69);
    checkAll("legal", 1'b0, 3'd0, 2'b00, 16'd3);

    // dir2 yellow held into a 4th tick. dir1 red started on the same tick
    // as dir2 green, so its red reaches 11 on that very tick as well.
    runSeconds(70, 79);
    setLamps({LR, LY});
    one_sec = 1'b1;
    #1;
    checkOutput("long.latency_pre", {15'd0, fault}, 16'd0);
    @(negedge clk);
    one_sec = 1'b0;
    checkAll("long", 1'b1, 3'd5, 2'b11, 16'd3);

    // Outputs stay frozen in FAULT even with conflicting lamps.
    applyStimulus({LG, LG}, 1'b1, 1'b0);
    applyStimulus({LR, LY}, 1'b0, 1'b0);
    checkOutput("frozen.code", {13'd0, fault_code}, 16'd5);

    // Clear with legal lamps returns to SYNC; cycles kept.
    applyStimulus({LR, LY}, 1'b0, 1'b1);
    checkAll("clr", 1'b0, 3'd0, 2'b00, 16'd3);

    // Re-arm at s=100, then dir1 green -> red without yellow.
    runSeconds(97, 104);
    applyStimulus({LR, LR}, 1'b0, 1'b0);
    checkAll("order", 1'b1, 3'd3, 2'b01, 16'd3);

    // clr while both directions show green: the violation wins.
    applyStimulus({LG, LG}, 1'b0, 1'b1);
    checkAll("clr_vs_conflict", 1'b1, 3'd2, 2'b11, 16'd3);

    // Legal clear, then both green in SYNC.
    applyStimulus({LG, LR}, 1'b0, 1'b1);
    checkOutput("clr2.fault", {15'd0, fault}, 16'd0);
    applyStimulus({LG, LG}, 1'b0, 1'b0);
    checkAll("conflict", 1'b1, 3'd2, 2'b11, 16'd3);

    // Clear, re-arm (s=127/130), count one more cycle at s=140, then
    // dir1 illegal while dir2 greens early: encoding wins.
    applyStimulus(phaseLamps(120), 1'b0, 1'b1);
    checkOutput("clr3.fault", {15'd0, fault}, 16'd0);
    runSeconds(120, 142);
    checkAll("pre_illegal", 1'b0, 3'd0, 2'b00, 16'd4);
    applyStimulus({3'b110, LG}, 1'b1, 1'b0);
    checkAll("illegal", 1'b1, 3'd1, 2'b01, 16'd4);

    // Asynchronous reset in the middle of a FAULT, between clock edges.
    #2 reset = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 3'd0, 2'b00, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
